mem_access_sequencer: RTL

- Parametrised, multi-requester memory access engine for the PDP-8 CPU datapath.
- Replaces the per-instruction read/write/increment handshake sequences (fetch, indirect, auto-index, ISZ, DCA, JMS) with one shared sequencer.
- Round-robin arbitration across N_REQ requesters, e.g. controller, front-panel deposit and EAE operand fetch.
- Runs READ, WRITE and read-modify-write (increment/decrement) against the memory mem_finished handshake, with a timeout.

---
 rtl/mem_access_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
// Shared memory access engine for the PDP-8 datapath. Round-robin arbitration
// across N_REQ requester channels, then one READ, WRITE or read-modify-write
// (increment/decrement) run against the memory mem_finished handshake. Each
// wait for mem_finished has an optional cycle timeout.
//
// Handshake: a channel raises req with op/addr/wdata stable and holds them
// until it sees its one-cycle done pulse (err rides along on a timeout). The
// channel drops req on that same edge. done is the only acknowledgement; a
// req dropped before done does not cancel the access.
//
// Ports:
//   clock, resetN          rising-edge clock, asynchronous active-low reset
//   req[N_REQ]             per-channel request
//   op[2*N_REQ]            per-channel op: 00 READ, 01 WRITE, 10 INC, 11 DEC
//   addr, wdata            per-channel address and write data, packed by channel
//   done, err[N_REQ]       completion / timeout pulse to the granted channel
//   rdata, zero            read or modified value and RMW zero flag
//   busy                   high whenever the sequencer is not idle
//   mem_*                  memory address, data, strobes and completion
module mem_access_sequencer #(
  parameter int WORD_W      = 12,
  parameter int ADDR_W      = 12,
  parameter int N_REQ       = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                      clock,
  input  logic                      resetN,
  input  logic [N_REQ-1:0]          req,
  input  logic [2*N_REQ-1:0]        op,
  input  logic [N_REQ*ADDR_W-1:0]   addr,
  input  logic [N_REQ*WORD_W-1:0]   wdata,
  output logic [N_REQ-1:0]          done,
  output logic [N_REQ-1:0]          err,
  output logic [WORD_W-1:0]         rdata,
  output logic                      zero,
  output logic                      busy,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [WORD_W-1:0]         mem_write_data,
  output logic                      mem_read_enable,
  output logic                      mem_write_enable,
  input  logic [WORD_W-1:0]         mem_read_data,
  input  logic                      mem_finished
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // The counter only has to reach TIMEOUT_CYC-1: the timeout fires on the
  // cycle that would take it to TIMEOUT_CYC.
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TLIM = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_DEC   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_MODIFY = 3'd2,
    S_WRITE  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [GW-1:0]     rr;          // last granted channel; also the current grant
  logic [GW-1:0]     pick;
  logic [GW-1:0]     idx;
  logic              found;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] data_q;
  logic [WORD_W-1:0] rdata_q;
  logic [WORD_W-1:0] mod_result;
  logic              zero_q;
  logic              err_q;
  logic [TW-1:0]     tcnt;
  logic              timeout_hit;

  // Round-robin search starting one past the last grant.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = GW'((int'(rr) + i) % N_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // mem_finished in the limit cycle still counts as a completion.
  assign timeout_hit = (TIMEOUT_CYC > 0) && !mem_finished && (tcnt == TLIM);

  assign mod_result = (op_q == OP_DEC) ? (data_q - 1'b1) : (data_q + 1'b1);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (found) state_n = (op[2*pick +: 2] == OP_WRITE) ? S_WRITE : S_READ;
      end
      S_READ: begin
        if (mem_finished)     state_n = (op_q == OP_READ) ? S_RESP : S_MODIFY;
        else if (timeout_hit) state_n = S_RESP;  // RMW write is skipped
      end
      S_MODIFY: state_n = S_WRITE;
      S_WRITE: begin
        if (mem_finished || timeout_hit) state_n = S_RESP;
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rr      <= GW'(N_REQ - 1);
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      tcnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            rr      <= pick;
            op_q    <= op[2*pick +: 2];
            addr_q  <= addr[pick*ADDR_W +: ADDR_W];
            wdata_q <= wdata[pick*WORD_W +: WORD_W];
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
            tcnt    <= '0;
          end
        end
        S_READ: begin
          if (mem_finished) begin
            data_q <= mem_read_data;
            if (op_q == OP_READ) rdata_q <= mem_read_data;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end else if (TIMEOUT_CYC > 0) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_MODIFY: begin
          data_q <= mod_result;
          zero_q <= (mod_result == '0);
          tcnt   <= '0;
        end
        S_WRITE: begin
          if (mem_finished) begin
            // Plain WRITE has nothing to return, so rdata keeps its old value.
            if (op_q != OP_WRITE) rdata_q <= data_q;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end else if (TIMEOUT_CYC > 0) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs: everything decodes from the registered state so reset
  // drops the strobes without waiting for a clock.
  assign busy             = (state != S_IDLE);
  assign mem_read_enable  = (state == S_READ);
  assign mem_write_enable = (state == S_WRITE);
  assign mem_address      = (state == S_READ || state == S_WRITE) ? addr_q : '0;
  assign mem_write_data   = (state == S_WRITE) ? ((op_q == OP_WRITE) ? wdata_q : data_q) : '0;
  assign rdata            = rdata_q;
  assign zero             = (state == S_RESP) && zero_q && !err_q;

  always_comb begin
    done = '0;
    err  = '0;
    if (state == S_RESP) begin
      done[rr] = 1'b1;
      err[rr]  = err_q;
    end
  end

endmodule
